// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD countdown timer.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Clamp a raw nibble into the valid BCD digit range.
  function automatic logic [3:0] bcd_sat(input logic [3:0] raw);
    return (raw > BCD_MAX) ? BCD_MAX : raw;
  endfunction

  // True when a raw nibble is not a legal BCD digit.
  function automatic logic bcd_invalid(input logic [3:0] raw);
    return (raw > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_down_digit.sv
// One BCD digit of the down-counter: loadable, decrements on borrow_in,
// wraps 0 -> 9 and forwards the borrow to the next digit.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       is_zero
);

  logic [3:0] digit_r;

  // Digit register: load has priority over decrement; 0 wraps to 9 on borrow.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_r <= 4'd0;
    end else if (load) begin
      digit_r <= load_digit;
    end else if (borrow_in) begin
      digit_r <= (digit_r == 4'd0) ? BCD_MAX : (digit_r - 4'd1);
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit      = digit_r;
  assign is_zero    = (digit_r == 4'd0);
  assign borrow_out = is_zero && borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load, start/pause and auto-reload.
// All state changes happen on the falling edge of clk.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  import bcd_pkg::*;

  localparam logic [4*DIGITS-1:0] COUNT_ZERO = {(4*DIGITS){1'b0}};
  localparam logic [4*DIGITS-1:0] COUNT_ONE  = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [4*DIGITS-1:0] reload_r;
  logic                done_r;
  logic                load_err_r;

  logic [4*DIGITS-1:0] sanitized_s;
  logic                load_err_s;
  logic [4*DIGITS-1:0] digit_load_val_s;
  logic                digit_load_s;
  logic                dec_s;
  logic                expire_s;
  logic                reload_now_s;
  logic                one_s;
  logic [DIGITS:0]     borrow_s;
  logic [DIGITS-1:0]   zero_vec_s;
  logic                unused_borrow_s;

  // Saturate each incoming digit and flag any that were out of BCD range.
  always_comb begin
    sanitized_s = COUNT_ZERO;
    load_err_s  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      sanitized_s[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
      if (bcd_invalid(load_val[4*i +: 4])) begin
        load_err_s = 1'b1;
      end else begin
        load_err_s = load_err_s;
      end
    end
  end

  assign zero         = &zero_vec_s;
  assign one_s        = (count == COUNT_ONE);
  // A qualified tick: only in RUN, and pause or load in the same cycle swallow it.
  assign dec_s        = (state_r == RUN) && tick && !pause && !load;
  assign expire_s     = dec_s && one_s;
  assign reload_now_s = expire_s && auto_reload && (reload_r != COUNT_ZERO);
  assign digit_load_s = load || reload_now_s;

  // Digit load source: an external load wins over the auto-reload value.
  always_comb begin
    if (load) begin
      digit_load_val_s = sanitized_s;
    end else begin
      digit_load_val_s = reload_r;
    end
  end

  assign borrow_s[0]     = dec_s;
  assign unused_borrow_s = borrow_s[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (digit_load_s),
      .load_digit (digit_load_val_s[4*i +: 4]),
      .borrow_in  (borrow_s[i]),
      .digit      (count[4*i +: 4]),
      .borrow_out (borrow_s[i+1]),
      .is_zero    (zero_vec_s[i])
    );
  end

  // Control FSM with reload register and the one-cycle done/load_err pulses.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      reload_r   <= COUNT_ZERO;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
      if (load) begin
        state_r    <= IDLE;
        reload_r   <= sanitized_s;
        load_err_r <= load_err_s;
      end else begin
        case (state_r)
          IDLE: begin
            if (start && !zero) state_r <= RUN;
            else                state_r <= IDLE;
          end
          RUN: begin
            if (pause) begin
              state_r <= PAUSE;
            end else if (expire_s) begin
              done_r  <= 1'b1;
              state_r <= reload_now_s ? RUN : IDLE;
            end else begin
              state_r <= RUN;
            end
          end
          PAUSE: begin
            if (start && !pause) state_r <= RUN;
            else                 state_r <= PAUSE;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_r != IDLE);
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios followed by
// random stimulus, compared against an integer-valued reference model.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] count;
  logic        busy, zero, done, load_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: count held as a plain integer 0..9999.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_count, m_reload, m_state;
  bit m_done, m_err;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick), .auto_reload(auto_reload),
    .count(count), .busy(busy), .zero(zero), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [15:0] b);
    bit bad = 1'b0;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_state = M_IDLE; m_done = 0; m_err = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".count"},    32'(count),    32'(int_to_bcd(m_count)));
    check_eq({tag, ".busy"},     32'(busy),     32'(m_state != M_IDLE));
    check_eq({tag, ".zero"},     32'(zero),     32'(m_count == 0));
    check_eq({tag, ".done"},     32'(done),     32'(m_done));
    check_eq({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the falling edge.
  task automatic step(input bit l, input logic [15:0] lv, input bit s, input bit p,
                      input bit t, input bit ar, input string tag);
    load = l; load_val = lv; start = s; pause = p; tick = t; auto_reload = ar;
    m_done = 0; m_err = 0;
    if (l) begin
      m_count = bcd_to_int(lv); m_reload = m_count; m_state = M_IDLE; m_err = bcd_bad(lv);
    end else begin
      case (m_state)
        M_IDLE:  if (s && m_count != 0) m_state = M_RUN;
        M_RUN: begin
          if (p) m_state = M_PAUSE;
          else if (t) begin
            if (m_count == 1) begin
              m_done = 1;
              if (ar && m_reload != 0) m_count = m_reload;
              else begin m_count = 0; m_state = M_IDLE; end
            end else m_count = m_count - 1;
          end
        end
        M_PAUSE: if (s && !p) m_state = M_RUN;
        default: m_state = M_IDLE;
      endcase
    end
    @(negedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); reset_n = 1'b1;
    @(negedge clk); #1;

    // Countdown from 103 with continuous ticks.
    step(1, 16'h0103, 0, 0, 0, 0, "ld103");
    step(0, 16'h0000, 1, 0, 0, 0, "start103");
    for (int i = 0; i < 103; i++) step(0, 16'h0000, 0, 0, 1, 0, "run103");
    check_eq("after103.count", 32'(count), 32'h0000);
    check_eq("after103.busy", 32'(busy), 32'h0);

    // Saturating load.
    step(1, 16'h1A5F, 0, 0, 0, 0, "ld1A5F");
    check_eq("sat.count", 32'(count), 32'h1959);
    step(0, 16'h0000, 0, 0, 0, 0, "sat.idle");

    // Auto-reload from 3.
    step(1, 16'h0003, 0, 0, 0, 1, "ld3");
    step(0, 16'h0000, 1, 0, 0, 1, "start3");
    for (int i = 0; i < 6; i++) step(0, 16'h0000, 0, 0, 1, 1, "ar3");

    // Pause and tick together, ticks during pause, resume.
    step(1, 16'h0050, 0, 0, 0, 0, "ld50");
    step(0, 16'h0000, 1, 0, 0, 0, "start50");
    step(0, 16'h0000, 0, 1, 1, 0, "pausetick");
    for (int i = 0; i < 3; i++) step(0, 16'h0000, 0, 0, 1, 0, "pausedtick");
    step(0, 16'h0000, 1, 0, 1, 0, "resume");
    step(0, 16'h0000, 0, 0, 1, 0, "tick49");
    check_eq("resume.count", 32'(count), 32'h0049);

    // Start at zero, then load over a running count.
    step(1, 16'h0000, 0, 0, 0, 0, "ld0");
    step(0, 16'h0000, 1, 0, 1, 0, "start0");
    step(0, 16'h0000, 0, 0, 1, 0, "idle0");
    step(1, 16'h0025, 0, 0, 0, 0, "ld25");
    step(0, 16'h0000, 1, 0, 0, 0, "start25");
    for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 0, 1, 0, "run25");
    step(1, 16'h9999, 1, 0, 1, 0, "ld9999");
    step(0, 16'h0000, 1, 0, 0, 0, "start9999");
    for (int i = 0; i < 3; i++) step(0, 16'h0000, 0, 0, 1, 0, "wrap9999");

    // Asynchronous reset mid-run.
    step(1, 16'h0007, 0, 0, 0, 0, "ld7");
    step(0, 16'h0000, 1, 0, 0, 0, "start7");
    step(0, 16'h0000, 0, 0, 1, 0, "run7");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset_n = 1'b1;
    step(0, 16'h0000, 1, 0, 1, 0, "post_rst_start");
    step(0, 16'h0000, 0, 0, 1, 0, "post_rst_tick");

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      bit          l  = ($urandom_range(0, 19) == 0);
      logic [15:0] lv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : int_to_bcd($urandom_range(0, 40));
      bit          s  = ($urandom_range(0, 3) == 0);
      bit          p  = ($urandom_range(0, 7) == 0);
      bit          t  = ($urandom_range(0, 3) != 0);
      bit          ar = 1'($urandom);
      step(l, lv, s, p, t, ar, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with load, start/pause control and optional auto-reload. It is the counting-down counterpart of the team's decade up-counter. It feeds BCD digits directly to the display path and produces a one-cycle `done` pulse on expiry. It sits between a tick prescaler and the seven-segment driver.

## Interface
- `DIGITS`, default 4: number of BCD digits; count width is 4*DIGITS.
- `clk`, input, 1: clock; all state changes on the falling edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `load`, input, 1: load `load_val` into count and the reload register; highest priority.
- `load_val`, input, 4*DIGITS: BCD load value; digit i is bits [4i+3:4i].
- `start`, input, 1: begin or resume counting.
- `pause`, input, 1: suspend counting.
- `tick`, input, 1: count enable from the prescaler; one decrement per qualified tick.
- `auto_reload`, input, 1: on expiry, reload from the reload register and keep running.
- `count`, output, 4*DIGITS: current BCD count (registered).
- `busy`, output, 1: state is not IDLE.
- `zero`, output, 1: count == 0 (combinational from the count register).
- `done`, output, 1: one-cycle pulse on expiry.
- `load_err`, output, 1: one-cycle pulse when any `load_val` digit is greater than 9.

## Operation
- States: IDLE, RUN, PAUSE.
- Reset values: state IDLE; count 0; reload register 0; `done` 0; `load_err` 0; `busy` 0; `zero` 1.
- `load` (any state):
  - Each digit greater than 9 is saturated to 9 before storage.
  - The sanitized value goes to both count and the reload register.
  - Next state is IDLE. `load_err` pulses if any digit was saturated.
  - `start`, `pause` and `tick` are ignored in the same cycle.
- IDLE:
  - `start` with count != 0 moves to RUN.
  - `start` with count == 0 stays in IDLE; no `done` pulse.
  - `tick` is ignored.
- RUN, transitions:
  - `pause` moves to PAUSE. `pause` beats `start`; a `tick` in the same cycle is discarded.
- RUN, `tick` with count > 1:
  - Decrement by 1.
  - Digit i decrements when all lower digits are 0 (borrow chain); a digit at 0 receiving a borrow wraps to 9.
- RUN, `tick` with count == 1 (expiry):
  - `done` pulses.
  - If `auto_reload`=1 and reload != 0: count loads the reload value and the state stays RUN.
  - Otherwise: count becomes 0 and the state moves to IDLE.
- PAUSE:
  - `start` without `pause` returns to RUN.
  - `tick` is ignored and count holds.
- `auto_reload` is sampled only at expiry; changing it mid-run has no other effect.
- The count never leaves the valid BCD range, including at the all-9s maximum.

## Timing
- `count`, `done` and `load_err` update on the same falling edge that samples the causing input; there are no extra pipeline stages.
- `done` is high for exactly one cycle, coincident with count showing 0 (or the reloaded value).
- Back-to-back ticks decrement on consecutive cycles; with `tick` held high, expiry from N takes N cycles.
- First decrement happens on the first `tick` after the cycle in which RUN is entered.
- `reset_n` asserted mid-run forces all outputs to their reset values immediately, without waiting for a clock edge. Release is synchronized by the integrator; the block requires deassertion away from the falling edge.

## Structure
- Package `bcd_pkg`:
  - `BCD_W` = 4; `BCD_MAX` = 9.
  - State encoding constants IDLE/RUN/PAUSE.
  - A saturating function mapping 4 bits to a BCD digit.
- Sub-module `bcd_down_digit`, instantiated DIGITS times:
  - Inputs: `clk`, `reset_n`, `load`, `load_digit`, `borrow_in`.
  - Outputs: `digit`, `borrow_out`, `is_zero`.
  - Decrements on `borrow_in`; wraps 0 to 9 and asserts `borrow_out` combinationally when `digit == 0 && borrow_in`.
- Top level holds the FSM, reload register, expiry detect (count == 1) and the auto-reload mux.

## Test plan
All scenarios use DIGITS=4.
- Load 0x0103, start, tick every cycle: count sequence 0x0102, 0x0101, 0x0100, 0x0099. After 103 ticks count = 0x0000, `done` pulses once, `busy` falls.
- Load 0x1A5F: count = 0x1959, `load_err` high for one cycle; count and `busy` otherwise unaffected.
- Load 0x0003 with `auto_reload`=1, start, continuous ticks: count 2, 1, 3, 2, 1, 3. `done` pulses each time count goes to 3; state stays RUN.
- RUN at 0x0050; `pause` and `tick` in the same cycle: count stays 0x0050. Ticks while in PAUSE do not change it. `start` then one tick gives 0x0049.
- IDLE with count 0, `start` pulse: `busy` stays 0, no `done`. Load 0x9999 while RUN at 0x0020: count = 0x9999, state IDLE.
- RUN at 0x0007, assert `reset_n` low between clock edges: count = 0, `busy` = 0, `zero` = 1 immediately. After release, `start` has no effect until the next load.
